// File: rtl/irq_pkg.sv
// irq_pkg: shared types and helpers for the interrupt controller.
//   irq_state_e : controller FSM state encoding
//   id_width()  : width of the source-index bus for a given source count
package irq_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_PEND    = 2'b01,
        S_HANDLER = 2'b10,
        S_GUARD   = 2'b11
    } irq_state_e;

    // Index width; a single source still needs one bit to carry index 0.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder.
//   vec_i   : request vector (bit 0 is highest priority)
//   idx_o   : index of lowest set bit (0 when none set)
//   valid_o : any bit of vec_i set
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int N_IRQ = 6,
    parameter int ID_W  = id_width(N_IRQ)
) (
    input  logic [N_IRQ-1:0] vec_i,
    output logic [ID_W-1:0]  idx_o,
    output logic             valid_o
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx_o   = '0;
        valid_o = |vec_i;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            idx_o = vec_i[i] ? ID_W'(i) : idx_o;
        end
    end

endmodule

// File: rtl/irq_controller.sv
// irq_controller: interrupt entry/exit sequencer for an in-order pipeline.
// Build option: define IRQ_EDGE_LATCH_EN to capture rising edges of irq_i
// into sticky pending bits; otherwise sources are level sensitive.
//   clk, reset          : clock, asynchronous active-high reset
//   irq_i, im_i, ie_i   : sources, per-source mask, global enable
//   xfer_i, stall_i     : pipeline conditions that block interrupt entry
//   eret_i              : return-from-exception decoded in ID
//   take_o              : one-cycle pulse, enter handler
//   exl_o, exl_clr_o    : exception level flag and its clear pulse
//   irq_id_o, cause_ip_o: taken source index and pending-enabled snapshot
module irq_controller
    import irq_pkg::*;
#(
    parameter int N_IRQ     = 6,
    parameter int GUARD_CYC = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_IRQ-1:0]            irq_i,
    input  logic [N_IRQ-1:0]            im_i,
    input  logic                        ie_i,
    input  logic                        xfer_i,
    input  logic                        stall_i,
    input  logic                        eret_i,
    output logic                        take_o,
    output logic                        exl_o,
    output logic                        exl_clr_o,
    output logic [id_width(N_IRQ)-1:0]  irq_id_o,
    output logic [N_IRQ-1:0]            cause_ip_o
);

    localparam int         ID_W     = id_width(N_IRQ);
    localparam logic [3:0] GUARD_LD = 4'(GUARD_CYC);

    irq_state_e        state_q, state_d;
    logic              take_q, take_d;
    logic              exl_q, exl_d;
    logic              exl_clr_q, exl_clr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [N_IRQ-1:0]  cause_q, cause_d;
    logic [3:0]        cnt_q, cnt_d;

    logic [N_IRQ-1:0]  src_s;
    logic [N_IRQ-1:0]  hit_s;
    logic [ID_W-1:0]   enc_idx_s;
    logic              enc_valid_s;
    logic              req_s;
    logic              block_s;

`ifdef IRQ_EDGE_LATCH_EN
    logic [N_IRQ-1:0]  pend_q, pend_d;
    logic [N_IRQ-1:0]  prev_q;
    logic [N_IRQ-1:0]  clr_s;

    // Sticky pending bits: clear the taken source, then OR in fresh rising
    // edges so a same-cycle edge on the taken bit survives.
    always_comb begin
        clr_s = '0;
        if (take_d) begin
            clr_s[enc_idx_s] = 1'b1;
        end else begin
            clr_s = '0;
        end
        pend_d = (pend_q & ~clr_s) | (irq_i & ~prev_q);
    end

    // Pending vector and previous-sample registers for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
            prev_q <= '0;
        end else begin
            pend_q <= pend_d;
            prev_q <= irq_i;
        end
    end

    assign src_s = pend_q;
`else
    assign src_s = irq_i;
`endif

    assign hit_s   = src_s & im_i;
    assign block_s = xfer_i | stall_i;
    assign req_s   = ie_i & enc_valid_s;

    irq_prio_enc #(
        .N_IRQ (N_IRQ),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .vec_i   (hit_s),
        .idx_o   (enc_idx_s),
        .valid_o (enc_valid_s)
    );

    // Next-state and next-output logic of the entry/exit sequencer.
    always_comb begin
        state_d   = state_q;
        take_d    = 1'b0;
        exl_clr_d = 1'b0;
        exl_d     = exl_q;
        id_d      = id_q;
        cause_d   = cause_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                exl_d   = 1'b0;
                state_d = req_s ? S_PEND : S_IDLE;
            end
            S_PEND: begin
                if (!req_s) begin
                    state_d = S_IDLE;
                end else if (block_s) begin
                    state_d = S_PEND;
                end else begin
                    state_d = S_HANDLER;
                    take_d  = 1'b1;
                    id_d    = enc_idx_s;
                    cause_d = hit_s;
                    exl_d   = 1'b1;
                end
            end
            S_HANDLER: begin
                // eret waits out a stall; new requests are not looked at here.
                if (eret_i && !stall_i) begin
                    exl_clr_d = 1'b1;
                    exl_d     = 1'b0;
                    if (GUARD_LD == 4'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GUARD;
                        cnt_d   = GUARD_LD;
                    end
                end else begin
                    state_d = S_HANDLER;
                end
            end
            S_GUARD: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            take_q    <= 1'b0;
            exl_q     <= 1'b0;
            exl_clr_q <= 1'b0;
            id_q      <= '0;
            cause_q   <= '0;
            cnt_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            take_q    <= take_d;
            exl_q     <= exl_d;
            exl_clr_q <= exl_clr_d;
            id_q      <= id_d;
            cause_q   <= cause_d;
            cnt_q     <= cnt_d;
        end
    end

    assign take_o     = take_q;
    assign exl_o      = exl_q;
    assign exl_clr_o  = exl_clr_q;
    assign irq_id_o   = id_q;
    assign cause_ip_o = cause_q;

endmodule
